// File: rtl/wcc_video_timing_if.sv
`default_nettype none
// ============================================================================
// Module   : wcc_video_timing_if
// Brief    : Mode inputs and raster outputs of the WCC video timing generator.
//            The master modport belongs to the timing generator. The slave
//            modport belongs to the pixel generator and the emu top.
// Revision : 1.0 - initial release
// ============================================================================
interface wcc_video_timing_if;
  logic       pal;
  logic       scandouble;
  logic       ce_pix;
  logic [8:0] hcount;
  logic [9:0] vcount;
  logic       HBlank;
  logic       HSync;
  logic       VBlank;
  logic       VSync;
  logic       frame_start;
  logic       pal_active;
  logic [7:0] frame_cnt;

  modport master (
    input  pal, scandouble,
    output ce_pix, hcount, vcount, HBlank, HSync, VBlank, VSync,
           frame_start, pal_active, frame_cnt
  );

  modport slave (
    output pal, scandouble,
    input  ce_pix, hcount, vcount, HBlank, HSync, VBlank, VSync,
           frame_start, pal_active, frame_cnt
  );
endinterface
`default_nettype wire

// File: rtl/wcc_video_timing.sv
`default_nettype none
// ============================================================================
// Module   : wcc_video_timing
// Brief    : Raster timing generator. Produces the pixel enable, the beam
//            counters and the blank/sync strobes for NTSC/PAL, 15 or 31 kHz.
//            The mode is latched only at frame boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module wcc_video_timing #(
  parameter int CE_DIV   = 8,
  parameter int H_ACTIVE = 320,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 32,
  parameter int H_TOTAL  = 384
) (
  input  wire logic          clk,
  input  wire logic          reset,
  wcc_video_timing_if.master vid
);

  localparam int C_DIV_W = $clog2(CE_DIV);

  localparam logic [C_DIV_W-1:0] C_DIV_LAST_15K = C_DIV_W'(CE_DIV - 1);
  localparam logic [C_DIV_W-1:0] C_DIV_LAST_31K = C_DIV_W'(CE_DIV / 2 - 1);

  localparam logic [8:0] C_H_LAST     = 9'(H_TOTAL - 1);
  localparam logic [8:0] C_H_ACT      = 9'(H_ACTIVE);
  localparam logic [8:0] C_HS_START   = 9'(H_ACTIVE + H_FP);
  localparam logic [8:0] C_HS_END     = 9'(H_ACTIVE + H_FP + H_SYNC);

  // Vertical geometry in logical (15 kHz) lines; scandouble doubles each value.
  localparam logic [9:0] C_VT_NTSC    = 10'd262;
  localparam logic [9:0] C_VT_PAL     = 10'd312;
  localparam logic [9:0] C_VA_NTSC    = 10'd240;
  localparam logic [9:0] C_VA_PAL     = 10'd288;
  localparam logic [9:0] C_VS_NTSC    = 10'd244;
  localparam logic [9:0] C_VS_PAL     = 10'd292;
  localparam logic [9:0] C_VS_LINES   = 10'd3;

  logic [C_DIV_W-1:0] r_div;
  logic               r_ce;
  logic [8:0]         r_h;
  logic [9:0]         r_v;
  logic               r_hblank;
  logic               r_hsync;
  logic               r_vblank;
  logic               r_vsync;
  logic               r_fs;
  logic               r_pal;
  logic               r_sd;
  logic [7:0]         r_frames;

  logic [C_DIV_W-1:0] w_div_last;
  logic               w_ce;
  logic [9:0]         w_v_last;
  logic               w_h_wrap;
  logic               w_bound;
  logic               w_pal_n;
  logic               w_sd_n;
  logic [8:0]         w_h_n;
  logic [9:0]         w_v_n;
  logic [9:0]         w_va_n;
  logic [9:0]         w_vs_lo_n;
  logic [9:0]         w_vs_hi_n;

  // Scale a logical line number to physical lines for the given scan rate.
  function automatic logic [9:0] f_scale(input logic [9:0] lines, input logic sd);
    return sd ? (lines << 1) : lines;
  endfunction

  // Next beam position, frame-boundary detection and the geometry that
  // applies to the position produced on the next pixel enable.
  always_comb begin
    w_div_last = r_sd ? C_DIV_LAST_31K : C_DIV_LAST_15K;
    // >= rather than == so a shorter period can never be overrun.
    w_ce       = (r_div >= w_div_last);
    w_v_last   = f_scale(r_pal ? C_VT_PAL : C_VT_NTSC, r_sd) - 10'd1;
    w_h_wrap   = (r_h == C_H_LAST);
    w_bound    = w_h_wrap && (r_v == w_v_last);
    w_pal_n    = w_bound ? vid.pal        : r_pal;
    w_sd_n     = w_bound ? vid.scandouble : r_sd;
    w_h_n      = w_h_wrap ? 9'd0 : r_h + 9'd1;
    if (w_bound) begin
      w_v_n = 10'd0;
    end else if (w_h_wrap) begin
      w_v_n = r_v + 10'd1;
    end else begin
      w_v_n = r_v;
    end
    w_va_n    = f_scale(w_pal_n ? C_VA_PAL : C_VA_NTSC, w_sd_n);
    w_vs_lo_n = f_scale(w_pal_n ? C_VS_PAL : C_VS_NTSC, w_sd_n);
    w_vs_hi_n = f_scale((w_pal_n ? C_VS_PAL : C_VS_NTSC) + C_VS_LINES, w_sd_n);
  end

  // Pixel clock divider: one-clk enable every N clks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
      r_ce  <= 1'b0;
    end else begin
      r_ce  <= w_ce;
      r_div <= w_ce ? '0 : r_div + 1'b1;
    end
  end

  // Beam counters, flags and mode latches, all updated on the same enable
  // edge so the decoded strobes never lag the counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h      <= '0;
      r_v      <= '0;
      r_hblank <= 1'b0;
      r_hsync  <= 1'b0;
      r_vblank <= 1'b0;
      r_vsync  <= 1'b0;
      r_fs     <= 1'b0;
      r_pal    <= 1'b0;
      r_sd     <= 1'b0;
      r_frames <= '0;
    end else if (w_ce) begin
      r_h      <= w_h_n;
      r_v      <= w_v_n;
      r_hblank <= (w_h_n >= C_H_ACT);
      r_hsync  <= (w_h_n >= C_HS_START) && (w_h_n < C_HS_END);
      r_vblank <= (w_v_n >= w_va_n);
      r_vsync  <= (w_v_n >= w_vs_lo_n) && (w_v_n < w_vs_hi_n);
      r_fs     <= w_bound;
      r_pal    <= w_pal_n;
      r_sd     <= w_sd_n;
      if (w_bound) begin
        r_frames <= r_frames + 8'd1;
      end
    end
  end

  assign vid.ce_pix      = r_ce;
  assign vid.hcount      = r_h;
  assign vid.vcount      = r_v;
  assign vid.HBlank      = r_hblank;
  assign vid.HSync       = r_hsync;
  assign vid.VBlank      = r_vblank;
  assign vid.VSync       = r_vsync;
  assign vid.frame_start = r_fs;
  assign vid.pal_active  = r_pal;
  assign vid.frame_cnt   = r_frames;

endmodule
`default_nettype wire

// File: tb/tb_wcc_video_timing.sv
`default_nettype none
// ============================================================================
// Module   : tb_wcc_video_timing
// Brief    : Self-checking bench for wcc_video_timing with a shrunken line
//            (8 pixels, CE_DIV=4) so whole frames stay short.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wcc_video_timing;
  localparam int CE  = 4;
  localparam int HA  = 4;
  localparam int HFP = 1;
  localparam int HS  = 2;
  localparam int HT  = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  wcc_video_timing_if vid();

  wcc_video_timing #(
    .CE_DIV(CE), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_TOTAL(HT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .vid   (vid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: time since the frame origin, converted to a pixel position.
  int    m_t, m_pos, m_frames, m_err;
  logic  m_pal, m_sd, m_ce, m_fs;
  string m_first = "";

  typedef struct {
    logic pal;
    logic sd;
    bit   toggle;
    int   len;
    int   maxv;
    int   vbl;
    int   vsf;
    int   vsl;
    logic pa;
  } row_t;
  row_t rows[5];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int vt_of(input logic pal, input logic sd);
    return (pal ? 312 : 262) * (sd ? 2 : 1);
  endfunction

  function automatic logic [33:0] exp_vec();
    int h, v, k, va, vs;
    logic hb, hs, vb, vsy;
    h   = m_pos % HT;
    v   = m_pos / HT;
    k   = m_sd ? 2 : 1;
    va  = (m_pal ? 288 : 240) * k;
    vs  = (m_pal ? 292 : 244) * k;
    hb  = (h >= HA);
    hs  = (h >= HA + HFP) && (h < HA + HFP + HS);
    vb  = (v >= va);
    vsy = (v >= vs) && (v < vs + 3 * k);
    return {m_ce, 9'(h), 10'(v), hb, hs, vb, vsy, m_fs, m_pal, 8'(m_frames)};
  endfunction

  function automatic logic [33:0] act_vec();
    return {vid.ce_pix, vid.hcount, vid.vcount, vid.HBlank, vid.HSync,
            vid.VBlank, vid.VSync, vid.frame_start, vid.pal_active, vid.frame_cnt};
  endfunction

  task automatic model_reset();
    m_t = 0; m_pos = 0; m_frames = 0;
    m_pal = 1'b0; m_sd = 1'b0; m_ce = 1'b0; m_fs = 1'b0;
  endtask

  task automatic model_cmp();
    logic [33:0] a, e;
    a = act_vec();
    e = exp_vec();
    if (a !== e) begin
      m_err++;
      if (m_err == 1) m_first = $sformatf("t=%0t got %h exp %h", $time, a, e);
    end
  endtask

  task automatic chk_raster(input string name);
    chk(name, m_err, 0);
    if (m_err != 0) $display("  first raster difference: %s", m_first);
  endtask

  // One clock: advance the model on the edge, then compare 1 time unit later.
  task automatic step();
    int n;
    @(posedge clk);
    if (!reset) begin
      n = m_sd ? CE / 2 : CE;
      m_t++;
      m_ce = (m_t % n == 0);
      if (m_ce) begin
        m_fs  = 1'b0;
        m_pos = m_t / n;
        if (m_pos == HT * vt_of(m_pal, m_sd)) begin
          m_pos    = 0;
          m_t      = 0;
          m_pal    = vid.pal;
          m_sd     = vid.scandouble;
          m_frames = (m_frames + 1) % 256;
          m_fs     = 1'b1;
        end
      end
    end
    #1;
    model_cmp();
  endtask

  // Run until the next frame_start rise, collecting geometry of the frame
  // in progress. Mode inputs wander randomly (or toggle pal explicitly) in
  // the first part of the frame and settle on the target later on.
  task automatic run_frame(input logic tp, input logic ts, input bit toggle,
                           output int len, output int maxv, output int vbl,
                           output int vsf, output int vsl);
    logic prev_fs;
    bit   done;
    len = 0; maxv = 0; vbl = 99999; vsf = 99999; vsl = -1;
    done = 1'b0;
    prev_fs = vid.frame_start;
    for (int i = 0; i < 12000 && !done; i++) begin
      if (vid.vcount >= 10'd200) begin
        vid.pal = tp;
        vid.scandouble = ts;
      end else if (toggle) begin
        if (vid.vcount == 10'd50)  vid.pal = 1'b0;
        if (vid.vcount == 10'd100) vid.pal = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        vid.pal = 1'($urandom);
        vid.scandouble = 1'($urandom);
      end
      step();
      len++;
      if (vid.frame_start && !prev_fs) begin
        done = 1'b1;
      end else begin
        if (int'(vid.vcount) > maxv) maxv = int'(vid.vcount);
        if (vid.VBlank && int'(vid.vcount) < vbl) vbl = int'(vid.vcount);
        if (vid.VSync && int'(vid.vcount) < vsf) vsf = int'(vid.vcount);
        if (vid.VSync && int'(vid.vcount) > vsl) vsl = int'(vid.vcount);
      end
      prev_fs = vid.frame_start;
    end
    if (!done) chk("frame_timeout", 1, 0);
  endtask

  initial begin
    int len, maxv, vbl, vsf, vsl;
    logic tp, ts;
    bit   hit;

    rows[0] = '{pal:1'b0, sd:1'b0, toggle:1'b0, len:8384, maxv:261, vbl:240, vsf:244, vsl:246, pa:1'b0};
    rows[1] = '{pal:1'b1, sd:1'b0, toggle:1'b0, len:9984, maxv:311, vbl:288, vsf:292, vsl:294, pa:1'b1};
    rows[2] = '{pal:1'b0, sd:1'b1, toggle:1'b0, len:8384, maxv:523, vbl:480, vsf:488, vsl:493, pa:1'b0};
    rows[3] = '{pal:1'b1, sd:1'b1, toggle:1'b0, len:9984, maxv:623, vbl:576, vsf:584, vsl:589, pa:1'b1};
    rows[4] = '{pal:1'b1, sd:1'b0, toggle:1'b1, len:9984, maxv:311, vbl:288, vsf:292, vsl:294, pa:1'b1};

    m_err = 0;
    vid.pal = 1'b0;
    vid.scandouble = 1'b0;
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", longint'(act_vec()), 0);

    // First pixel enable 4 clks after release, then every 4; line shape.
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      step();
      chk($sformatf("ce_clk%0d", i), vid.ce_pix, (i % 4 == 0));
      if (i == 12) chk("hcount_3", vid.hcount, 3);
      if (i == 16) chk("hblank_rise", vid.HBlank, 1);
      if (i == 16) chk("hsync_low_h4", vid.HSync, 0);
      if (i == 20) chk("hsync_rise_h5", vid.HSync, 1);
      if (i == 28) chk("hsync_fall_h7", vid.HSync, 0);
      if (i == 32) chk("hwrap_vcount", vid.vcount, 1);
      if (i == 32) chk("hwrap_hblank", vid.HBlank, 0);
    end

    // Finish the power-on frame, aiming the first boundary at row 0's mode.
    run_frame(rows[0].pal, rows[0].sd, 1'b0, len, maxv, vbl, vsf, vsl);
    chk("first_frame_cnt", vid.frame_cnt, 1);
    chk("first_frame_len", len, 8384 - 32);

    for (int r = 0; r < 5; r++) begin
      tp = (r < 4) ? rows[r + 1].pal : 1'b1;
      ts = (r < 4) ? rows[r + 1].sd  : 1'b1;
      chk($sformatf("row%0d_pal_active", r), vid.pal_active, rows[r].pa);
      chk($sformatf("row%0d_frame_cnt", r), vid.frame_cnt, r + 1);
      run_frame(tp, ts, rows[r].toggle, len, maxv, vbl, vsf, vsl);
      chk($sformatf("row%0d_len", r), len, rows[r].len);
      chk($sformatf("row%0d_last_line", r), maxv, rows[r].maxv);
      chk($sformatf("row%0d_vblank_line", r), vbl, rows[r].vbl);
      chk($sformatf("row%0d_vsync_first", r), vsf, rows[r].vsf);
      chk($sformatf("row%0d_vsync_last", r), vsl, rows[r].vsl);
      chk_raster($sformatf("row%0d_raster", r));
    end
    chk("toggle_pal_kept", vid.pal_active, 1);

    // Asynchronous reset in the middle of a PAL scandoubled frame.
    hit = 1'b0;
    for (int i = 0; i < 5000 && !hit; i++) begin
      step();
      if (vid.vcount == 10'd100 && vid.hcount == 9'd5) hit = 1'b1;
    end
    chk("reached_v100", hit, 1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("async_reset_state", longint'(act_vec()), 0);
    repeat (2) step();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk($sformatf("post_reset_ce%0d", i), vid.ce_pix, (i % 4 == 0));
    end
    chk("post_reset_frame_cnt", vid.frame_cnt, 0);
    chk("post_reset_pal_active", vid.pal_active, 0);
    repeat (2000) step();
    chk_raster("final_raster");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wcc_video_timing.md
Name: wcc_video_timing

Overview:
Raster timing generator for the Atari WCC core. It produces the pixel clock-enable, the beam counters and the blank/sync strobes. The pixel/noise generator consumes these, and the emu top forwards them unchanged to CE_PIXEL, VGA_DE, VGA_HS and VGA_VS. It supports NTSC/PAL frame geometry and a 31 kHz scandoubled mode, and switches mode only at frame boundaries so the scaler never sees a torn frame.

Parameters:
CE_DIV, 8, clk cycles per pixel in 15 kHz mode; must be even and ≥4. Scandouble mode uses CE_DIV/2.
H_ACTIVE, 320, visible pixels per line.
H_FP, 16, front porch in pixels.
H_SYNC, 32, HSync width in pixels.
H_TOTAL, 384, pixels per line; back porch = H_TOTAL − H_ACTIVE − H_FP − H_SYNC = 16.

Ports:
clk  in  1  system clock (clk_sys)
reset  in  1  asynchronous, active-high
pal  in  1  0 = NTSC geometry, 1 = PAL; sampled at frame boundary
scandouble  in  1  1 = 31 kHz line-doubled timing; sampled at frame boundary
ce_pix  out  1  one-clk pixel enable
hcount  out  9  pixel within line, 0..H_TOTAL−1
vcount  out  10  physical line within frame, 0..VT−1
HBlank  out  1  horizontal blank
HSync  out  1  horizontal sync, active high
VBlank  out  1  vertical blank
VSync  out  1  vertical sync, active high
frame_start  out  1  one-ce pulse at hcount=0, vcount=0
pal_active  out  1  currently latched PAL mode
frame_cnt  out  8  frames completed, modulo 256

Behaviour:
- Reset is async. While asserted and on release: div=0, ce_pix=0, hcount=0, vcount=0, all blank/sync flags=0, frame_start=0, pal_l=0, sd_l=0, pal_active=0, frame_cnt=0. The first frame is always NTSC 15 kHz.
- Divider: N = sd_l ? CE_DIV/2 : CE_DIV.
  - div increments every clk.
  - When div ≥ N−1, div←0 and ce_pix=1 for that one clk.
  - The first ce_pix occurs N clks after reset release.
  - The ≥ compare guarantees wrap when N shrinks mid-count.
- Counters advance only on clks where ce_pix=1.
  - hcount wraps H_TOTAL−1 → 0 and increments vcount.
  - vcount wraps VT−1 → 0.
- Vertical geometry in logical lines:
  - NTSC: VT_L=262, active 0..239, VSync lines 244..246.
  - PAL: VT_L=312, active 0..287, VSync lines 292..294.
  - With sd_l=1, every threshold and total is doubled: VT=524/624, active 0..479/0..575, VSync 488..493 / 584..589.
- Flags are registered on the same ce edge as the counters and decode the new counter values, so they are always coherent with hcount/vcount and have zero skew.
  - HBlank = hcount ≥ H_ACTIVE.
  - HSync = H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC, i.e. 336..367.
  - VBlank = vcount ≥ active lines.
  - VSync = vcount within the sync window; asserts and deasserts at hcount=0.
- Frame boundary = the ce where hcount=H_TOTAL−1 and vcount=VT−1. On that ce:
  - pal_l←pal and sd_l←scandouble; the new geometry applies to the counters produced on the same edge.
  - frame_cnt increments, wrapping 255→0.
  - frame_start is registered high for exactly one ce period, from that edge until the next ce.
- pal/scandouble toggles mid-frame have no effect until the boundary. A toggle and a revert within one frame leaves the mode unchanged.
- pal_active = pal_l.
- Reset asserted mid-frame immediately returns to the reset state.
- Frame lengths in clks:
  - NTSC 15 kHz: 384·262·8 = 804,864
  - PAL 15 kHz: 384·312·8 = 958,464
  - NTSC scandoubled: 384·524·4 = 804,864
  - PAL scandoubled: 384·624·4 = 958,464

Test Plan:
1. Reset release, pal=0, scandouble=0 → first ce_pix at clk 8 after release, then every 8 clks. HSync rises on the ce producing hcount=336 and falls at hcount=368. HBlank rises at hcount=320.
2. NTSC free-run for 3 frames → frame_start spacing 804,864 clks. VBlank rises at vcount=240. VSync is high for lines 244–246 (3×3072 clks). frame_cnt reads 1, 2, 3.
3. Drive pal=1 at mid-frame → current frame still ends at vcount 261. The next frame has 312 lines, pal_active rises on the boundary ce, and frame_start spacing becomes 958,464 clks.
4. Set scandouble=1 mid-frame → after the boundary, ce_pix period is 4 clks, vcount reaches 523, VBlank rises at 480, and VSync covers lines 488–493. The frame is still 804,864 clks.
5. Toggle pal 1→0→1 within one frame → no geometry change at the boundary; pal_active stays 1.
6. Assert reset at hcount=200, vcount=100 with PAL/scandouble active → all outputs are 0 immediately (async). After release the timing is NTSC 15 kHz, and frame_cnt restarts from 0.
